// File: rtl/mux_sel_arbiter_pkg.sv
// Shared types and the round-robin pick function for the channel-select arbiter.
// Combinational helpers only: no latency and no flow control of their own.
package mux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Returns {found, index}: first set request bit, searching upward from ptr and wrapping.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                             input logic [SEL_W-1:0]  ptr);
    logic             found;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] cand;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = ptr + SEL_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the requesters and the channel-select arbiter.
// Wiring only: no latency; requesters hold req until done or withdrawal.
interface mux_sel_arbiter_if;
  import mux_pkg::*;

  logic [NUM_CH-1:0] req;
  logic              done;
  logic [SEL_W-1:0]  sel;
  logic [NUM_CH-1:0] grant;
  logic              busy;
  logic              timeout;

  modport master (
    output req,
    output done,
    input  sel,
    input  grant,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output sel,
    output grant,
    output busy,
    output timeout
  );

endinterface

// File: rtl/mux_sel_arbiter_pick.sv
// Rotate-then-priority-encode: first requester at or after ptr, wrapping.
// Purely combinational, zero latency, no backpressure.
module rr_priority_pick
  import mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              found,
  output logic [SEL_W-1:0]  index
);

  logic [SEL_W:0] pick;

  assign pick  = rr_pick(req, ptr);
  assign found = pick[SEL_W];
  assign index = pick[SEL_W-1:0];

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin 4-channel arbiter driving the downstream mux select; grant 1 cycle after req.
// Owner holds until done, withdrawal or timeout; other requesters wait, one idle cycle between grants.
module mux_sel_arbiter
  import mux_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_sel_arbiter_if.slave   bus
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state;
  logic [SEL_W-1:0]  sel_q;
  logic [NUM_CH-1:0] grant_q;
  logic              busy_q;
  logic              timeout_q;
  logic [SEL_W-1:0]  ptr;
  logic [CNT_W-1:0]  cnt;

  logic              pick_found;
  logic [SEL_W-1:0]  pick_idx;

  logic              owner_req;
  logic              to_hit;
  logic              rel;
  logic              to_only;

  rr_priority_pick u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  assign owner_req = bus.req[sel_q];
  assign to_hit    = (TIMEOUT != 0) && (cnt == CNT_LAST);
  assign rel       = bus.done || !owner_req || to_hit;
  // Pulse only when the counter alone forced the release.
  assign to_only   = to_hit && !bus.done && owner_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            sel_q   <= pick_idx;
            grant_q <= NUM_CH'(1) << pick_idx;
            busy_q  <= 1'b1;
            cnt     <= '0;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
          // sel is left alone on release so the mux input never glitches.
          if (rel) begin
            grant_q   <= '0;
            busy_q    <= 1'b0;
            ptr       <= sel_q + 1'b1;
            timeout_q <= to_only;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel     = sel_q;
  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule
